// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Fetch-PC sequencer. It owns the instruction fetch address and handles
//   sequential advance, hazard stalls, jump/branch redirects and exception
//   flushes. After each redirect or flush it inserts BUBBLES invalid fetch
//   cycles, and it counts consecutive stall cycles.
//
//   Event priority at every edge: flush_i > redir_valid_i > stall_i > sequential.
//   Every output is registered, so there is no combinational path from the
//   control inputs to pc_o, pc_valid_o, redir_taken_o, stall_cnt_o or state_o.
//
// Optional feature (define the PC_HIST_EN macro):
//   Adds a HIST_DEPTH-entry circular buffer that records every applied
//   redirect/flush target. It is read combinationally through hist_idx_i and
//   hist_pc_o, where index 0 is the newest entry.
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_n          in   asynchronous reset, active low
//   stall_i        in   hazard stall request (hold PC)
//   redir_valid_i  in   jump/branch redirect strobe
//   redir_pc_i     in   redirect target (low log2(STEP) bits ignored)
//   flush_i        in   exception flush to EXC_VEC
//   pc_o           out  fetch address
//   pc_valid_o     out  pc_o is a real fetch
//   redir_taken_o  out  one-cycle pulse after an applied redirect or flush
//   stall_cnt_o    out  consecutive stall cycles, saturating
//   state_o        out  0 IDLE, 1 RUN, 2 STALL, 3 BUBBLE
//   hist_idx_i     in   history read index, 0 = newest   (PC_HIST_EN only)
//   hist_pc_o      out  history entry                    (PC_HIST_EN only)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              PC_W       = 16,
  parameter int              STEP       = 1,
  parameter logic [PC_W-1:0] RESET_VEC  = '0,
  parameter logic [PC_W-1:0] EXC_VEC    = PC_W'('h10),
  parameter int              BUBBLES    = 1,
  parameter int              STALL_CW   = 8,
  parameter int              HIST_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                redir_valid_i,
  input  logic [PC_W-1:0]     redir_pc_i,
  input  logic                flush_i,
  output logic [PC_W-1:0]     pc_o,
  output logic                pc_valid_o,
  output logic                redir_taken_o,
  output logic [STALL_CW-1:0] stall_cnt_o,
  output logic [1:0]          state_o
`ifdef PC_HIST_EN
  ,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx_i,
  output logic [PC_W-1:0]               hist_pc_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2,
    ST_BUBBLE = 2'd3
  } state_t;

  // Redirect targets are forced onto a STEP boundary.
  localparam logic [PC_W-1:0] ALIGN_MASK  = ~(PC_W'(STEP) - PC_W'(1));
  localparam logic [PC_W-1:0] STEP_INC    = PC_W'(STEP);
  localparam logic [2:0]      BUB_INIT    = 3'(BUBBLES);
  localparam bit              HAS_BUBBLES = (BUBBLES > 0);

  // Elaboration-time parameter sanity checks.
  if (STEP < 1 || (STEP & (STEP - 1)) != 0) begin : g_chk_step
    $error("pc_sequencer: STEP must be a power of 2");
  end
  if (BUBBLES < 0 || BUBBLES > 7) begin : g_chk_bub
    $error("pc_sequencer: BUBBLES must be 0..7");
  end
  if (HIST_DEPTH < 2 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_chk_hist
    $error("pc_sequencer: HIST_DEPTH must be a power of 2 and >= 2");
  end

  // Saturating stall-counter increment.
  function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v);
    return (&v) ? v : v + STALL_CW'(1);
  endfunction

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  taken_q, taken_d;
  logic [STALL_CW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [2:0]            bub_q, bub_d;
  logic                  redir_apply;
  logic [PC_W-1:0]       redir_tgt;

  assign redir_apply = flush_i | redir_valid_i;
  assign redir_tgt   = flush_i ? EXC_VEC : (redir_pc_i & ALIGN_MASK);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    taken_d     = 1'b0;
    stall_cnt_d = '0;
    bub_d       = bub_q;

    if (redir_apply) begin
      // A redirect or flush wins over stall_i and restarts any bubble run.
      pc_d    = redir_tgt;
      taken_d = 1'b1;
      if (HAS_BUBBLES) begin
        state_d = ST_BUBBLE;
        valid_d = 1'b0;
        bub_d   = BUB_INIT;
      end else begin
        state_d = ST_RUN;
        valid_d = 1'b1;
        bub_d   = '0;
      end
    end else if (stall_i) begin
      // PC and valid hold. A bubble run freezes its count and stays in BUBBLE;
      // IDLE also stays put.
      stall_cnt_d = sat_inc(stall_cnt_q);
      if (state_q == ST_RUN || state_q == ST_STALL) begin
        state_d = ST_STALL;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // The first fetch after reset is RESET_VEC itself.
          state_d = ST_RUN;
          valid_d = 1'b1;
        end
        ST_RUN, ST_STALL: begin
          state_d = ST_RUN;
          valid_d = 1'b1;
          pc_d    = pc_q + STEP_INC;
        end
        ST_BUBBLE: begin
          // The redirect target becomes the first valid fetch; pc_q is unchanged.
          if (bub_q <= 3'd1) begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            bub_d   = '0;
          end else begin
            bub_d = bub_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VEC;
      valid_q     <= 1'b0;
      taken_q     <= 1'b0;
      stall_cnt_q <= '0;
      bub_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      taken_q     <= taken_d;
      stall_cnt_q <= stall_cnt_d;
      bub_q       <= bub_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_valid_o    = valid_q;
  assign redir_taken_o = taken_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign state_o       = state_q;

`ifdef PC_HIST_EN
  localparam int HIST_AW = $clog2(HIST_DEPTH);

  logic [PC_W-1:0]    hist_q [HIST_DEPTH];
  logic [HIST_AW-1:0] wptr_q, wptr_d;

  // wptr_q points at the slot that the next applied target will overwrite,
  // which is also the oldest entry once the buffer has wrapped.
  assign wptr_d = redir_apply ? wptr_q + HIST_AW'(1) : wptr_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= RESET_VEC;
      end
      wptr_q <= '0;
    end else begin
      if (redir_apply) begin
        hist_q[wptr_q] <= redir_tgt;
      end
      wptr_q <= wptr_d;
    end
  end

  // Newest entry sits just behind the write pointer; the index wraps modulo HIST_DEPTH.
  assign hist_pc_o = hist_q[wptr_q - HIST_AW'(1) - hist_idx_i];
`endif

endmodule
